pipelined_mips_hazard_controller: RTL and testbench
===================================================

Name: pipelined_mips_hazard_controller

Overview:
Sequences the 5-stage pipeline (IF/ID/EX/MEM/WB) that consumes the decoder's control bus.
- Keeps a shadow pipeline of destination-register and type info for EX, MEM and WB.
- Generates PC/IF-ID write enables, IF-ID and ID-EX flushes, EX-stage forwarding selects and an ID-stage WB bypass.
- Sits beside the datapath and is driven by the control bus of the instruction currently in ID.

Parameters:
None. Widths come from `MIPS_CONTROL_SIGNALS_WIDTH and the field offsets in constants.vh.

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_id_control_signals  in  `MIPS_CONTROL_SIGNALS_WIDTH  control bus of the ID instruction: {is_jump, is_branch, d[4:0], t[4:0], s[4:0], wr_addr_src, wr_data_src, wr_en, mem_we, alu_ctrl[2:0], alu_b_src[1:0]}.
- i_id_valid  in  1  ID holds a real instruction.
- i_ex_branch_taken  in  1  EX instruction is beq and compare equal.
- i_mem_stall  in  1  external freeze request.
- o_pc_write_enable  out  1  PC may update.
- o_if_id_write_enable  out  1  IF/ID register may load.
- o_if_id_flush  out  1  load a bubble into IF/ID.
- o_id_ex_flush  out  1  load a bubble into ID/EX.
- o_fwd_a_sel  out  2  EX operand A source: 00 = ID/EX register value, 01 = EX/MEM ALU result, 10 = MEM/WB write data.
- o_fwd_b_sel  out  2  EX operand B source, same encoding.
- o_id_wb_bypass_a  out  1  ID s-read takes WB write data instead of the register file.
- o_id_wb_bypass_b  out  1  same, for the t-read.

Behaviour:
- ID field decode:
  - reads_s = !is_jump.
  - reads_t = (alu_b_src == REGISTER_OUTPUT_2) | mem_we.
  - dest = wr_addr_src ? d : t. writes = wr_en & dest != 0.
  - is_load = wr_data_src.
  - A register address of 0 never matches anything.
- State: per stage (EX, MEM, WB) {valid, writes, dest, is_load}, plus registered fwd selects.
- Reset: all state and valid bits 0, fwd selects 00. Combinational outputs at reset: pc_we = 1, if_id_we = 1, both flushes 0, bypasses 0.
- Advance: each edge with !i_mem_stall, MEM→WB and EX→MEM shift. ID→EX loads the ID info, or a bubble (valid = 0) when the ID/EX flush is active or !i_id_valid.
- Load-use hazard: EX valid & is_load & writes, and EX dest matches an ID-read register. Response: pc_we = 0, if_id_we = 0, id_ex_flush = 1. Lasts exactly one cycle.
- Forwarding selects, computed at ID→EX transfer (latency 1, valid while the instruction is in EX):
  - 01 if the current-EX writer matches.
  - Else 10 if the current-MEM writer matches.
  - Else 00.
  - Youngest producer wins. Bubbles get 00.
- ID bypass: combinational. Asserted when WB valid & writes & dest matches the read register & that read is used.
- Jump in ID (valid): if_id_flush = 1, pc_we = 1. One cycle of penalty.
- Branch taken: if_id_flush = 1, id_ex_flush = 1, pc_we = 1, if_id_we = 1.
- Priority: reset > i_mem_stall > i_ex_branch_taken > load-use stall > jump.
  - i_mem_stall: pc_we = 0, if_id_we = 0, both flushes 0, no state change, fwd selects held.
  - Branch taken overrides a load-use stall in the same cycle, because the stalled instruction is squashed.
- Reset asserted mid-stall: everything clears immediately; the first cycle after release has no stall.

Optional Feature:
MIPS_HAZARD_FORWARDING_EN
- Defined: forwarding as above. A load-use dependency costs 1 stall cycle.
- Undefined:
  - fwd selects are tied to 00.
  - Any EX or MEM writer matching an ID read stalls, whether or not it is a load.
  - The stall uses the same signal pattern as load-use and repeats until the producer reaches WB.
  - A dependency on the immediately preceding producer therefore costs 2 cycles.
  - The ID WB bypass is retained.

Decomposition:
- constants.vh holds the control-bus field offsets (IS_JUMP_BIT, D_ADDR_LSB, etc.) and the FWD_SEL_REGFILE/EXMEM/MEMWB encodings.
- One sub-module: pipelined_mips_hazard_fields, a combinational unpacker of the control bus into reads_s, reads_t, dest, writes, is_load and is_jump.

Test Plan:
- add $3,$1,$2; add $4,$3,$1 (forwarding on) -> no stall; second add in EX sees fwd_a_sel = 01, fwd_b_sel = 00.
- lw $5,0($1); add $6,$5,$5 -> exactly 1 cycle with pc_we = 0, if_id_we = 0, id_ex_flush = 1; then the add in EX sees fwd_a = fwd_b = 10.
- beq taken (i_ex_branch_taken = 1) while ID holds a load-use consumer -> if_id_flush = 1, id_ex_flush = 1, pc_we = 1 in the same cycle; next cycle EX valid = 0.
- j in ID -> if_id_flush = 1 for 1 cycle, pc_we = 1; addi $0,$1,5 followed by add $2,$0,$0 -> fwd selects 00, no stall, no bypass.
- i_mem_stall held 3 cycles during a load-use stall -> all enables and flushes 0 for 3 cycles; after release, the identical single stall cycle, then fwd = 10.
- Without MIPS_HAZARD_FORWARDING_EN: add $3,$1,$2; sub $4,$3,$3 -> 2 stall cycles; then o_id_wb_bypass_a = o_id_wb_bypass_b = 1 for 1 cycle; fwd selects always 00.

Source files
------------

// File: rtl/pipelined_mips_hazard_controller_pkg.sv
// Shared types and control-bus field layout for the MIPS hazard controller.
// The MIPS_HAZARD_FORWARDING_EN build macro selects forwarding or stall-only mode.
package pipelined_mips_hazard_controller_pkg;

  localparam int CTRL_W = 26;

  localparam int ALU_B_SRC_LSB   = 0;
  localparam int ALU_CTRL_LSB    = 2;
  localparam int MEM_WE_BIT      = 5;
  localparam int WR_EN_BIT       = 6;
  localparam int WR_DATA_SRC_BIT = 7;
  localparam int WR_ADDR_SRC_BIT = 8;
  localparam int S_ADDR_LSB      = 9;
  localparam int T_ADDR_LSB      = 14;
  localparam int D_ADDR_LSB      = 19;
  localparam int IS_BRANCH_BIT   = 24;
  localparam int IS_JUMP_BIT     = 25;

  localparam logic [1:0] REGISTER_OUTPUT_2 = 2'b00;

  localparam logic [1:0] FWD_SEL_REGFILE = 2'b00;
  localparam logic [1:0] FWD_SEL_EXMEM   = 2'b01;
  localparam logic [1:0] FWD_SEL_MEMWB   = 2'b10;

  typedef struct packed {
    logic       reads_s;
    logic       reads_t;
    logic [4:0] s;
    logic [4:0] t;
    logic [4:0] dest;
    logic       writes;
    logic       is_load;
    logic       is_jump;
  } id_info_t;

  typedef struct packed {
    logic       valid;
    logic       writes;
    logic       is_load;
    logic [4:0] dest;
  } stage_t;

  // Register 0 is hardwired, so it never creates a dependency.
  function automatic logic hits(
    input stage_t     st,
    input logic [4:0] r,
    input logic       used
  );
    return used & st.valid & st.writes
         & (r != 5'd0) & (st.dest == r);
  endfunction

endpackage

// File: rtl/pipelined_mips_hazard_controller_if.sv
// Control-bus and hazard-response bundle between ID datapath and controller.
// Signal set is identical with or without MIPS_HAZARD_FORWARDING_EN.
interface pipelined_mips_hazard_controller_if;
  import pipelined_mips_hazard_controller_pkg::*;

  logic [CTRL_W-1:0] i_id_control_signals;
  logic              i_id_valid;
  logic              i_ex_branch_taken;
  logic              i_mem_stall;
  logic              o_pc_write_enable;
  logic              o_if_id_write_enable;
  logic              o_if_id_flush;
  logic              o_id_ex_flush;
  logic [1:0]        o_fwd_a_sel;
  logic [1:0]        o_fwd_b_sel;
  logic              o_id_wb_bypass_a;
  logic              o_id_wb_bypass_b;

  modport master (
    output i_id_control_signals,
    output i_id_valid,
    output i_ex_branch_taken,
    output i_mem_stall,
    input  o_pc_write_enable,
    input  o_if_id_write_enable,
    input  o_if_id_flush,
    input  o_id_ex_flush,
    input  o_fwd_a_sel,
    input  o_fwd_b_sel,
    input  o_id_wb_bypass_a,
    input  o_id_wb_bypass_b
  );

  modport slave (
    input  i_id_control_signals,
    input  i_id_valid,
    input  i_ex_branch_taken,
    input  i_mem_stall,
    output o_pc_write_enable,
    output o_if_id_write_enable,
    output o_if_id_flush,
    output o_id_ex_flush,
    output o_fwd_a_sel,
    output o_fwd_b_sel,
    output o_id_wb_bypass_a,
    output o_id_wb_bypass_b
  );

endinterface

// File: rtl/pipelined_mips_hazard_fields.sv
// Unpacks the ID control bus into the register-usage view the hazard logic needs.
// Independent of MIPS_HAZARD_FORWARDING_EN.
module pipelined_mips_hazard_fields
  import pipelined_mips_hazard_controller_pkg::*;
(
  input  logic [CTRL_W-1:0] i_ctrl,
  output id_info_t          o_info
);

  logic [1:0] w_alu_b_src;
  logic [4:0] w_dest;
  logic       w_unused;

  assign w_alu_b_src = i_ctrl[ALU_B_SRC_LSB +: 2];
  assign w_dest = i_ctrl[WR_ADDR_SRC_BIT]
                ? i_ctrl[D_ADDR_LSB +: 5]
                : i_ctrl[T_ADDR_LSB +: 5];

  assign w_unused = ^{i_ctrl[ALU_CTRL_LSB +: 3],
                      i_ctrl[IS_BRANCH_BIT]};

  always_comb begin
    o_info         = '0;
    o_info.reads_s = ~i_ctrl[IS_JUMP_BIT];
    o_info.reads_t = (w_alu_b_src == REGISTER_OUTPUT_2)
                   | i_ctrl[MEM_WE_BIT];
    o_info.s       = i_ctrl[S_ADDR_LSB +: 5];
    o_info.t       = i_ctrl[T_ADDR_LSB +: 5];
    o_info.dest    = w_dest;
    o_info.writes  = i_ctrl[WR_EN_BIT] & (w_dest != 5'd0);
    o_info.is_load = i_ctrl[WR_DATA_SRC_BIT];
    o_info.is_jump = i_ctrl[IS_JUMP_BIT];
  end

endmodule

// File: rtl/pipelined_mips_hazard_controller.sv
// Hazard/forwarding sequencer for a 5-stage MIPS pipeline.
// Define MIPS_HAZARD_FORWARDING_EN for forwarding; otherwise RAW hazards stall.
module pipelined_mips_hazard_controller
  import pipelined_mips_hazard_controller_pkg::*;
(
  input logic                               i_clk,
  input logic                               i_rst_n,
  pipelined_mips_hazard_controller_if.slave bus
);

  id_info_t w_id;
  stage_t   r_ex;
  stage_t   r_mem;
  stage_t   r_wb;

  logic w_s_ex;
  logic w_t_ex;
  logic w_s_mem;
  logic w_t_mem;
  logic w_stall;
  logic w_jump;
  logic w_bubble;
  logic w_pc_we;
  logic w_if_id_we;
  logic w_if_id_flush;
  logic w_id_ex_flush;
  logic w_unused;

  pipelined_mips_hazard_fields u_fields (
    .i_ctrl (bus.i_id_control_signals),
    .o_info (w_id)
  );

  assign w_s_ex  = hits(r_ex, w_id.s, w_id.reads_s);
  assign w_t_ex  = hits(r_ex, w_id.t, w_id.reads_t);
  assign w_s_mem = hits(r_mem, w_id.s, w_id.reads_s);
  assign w_t_mem = hits(r_mem, w_id.t, w_id.reads_t);
  assign w_jump  = bus.i_id_valid & w_id.is_jump;
  assign w_unused = r_wb.is_load;

`ifdef MIPS_HAZARD_FORWARDING_EN
  assign w_stall = bus.i_id_valid & r_ex.is_load
                 & (w_s_ex | w_t_ex);
`else
  // Without forwarding a consumer waits until its producer reaches WB.
  assign w_stall = bus.i_id_valid
                 & (w_s_ex | w_t_ex | w_s_mem | w_t_mem);
`endif

  always_comb begin
    w_pc_we       = 1'b1;
    w_if_id_we    = 1'b1;
    w_if_id_flush = 1'b0;
    w_id_ex_flush = 1'b0;
    priority case (1'b1)
      !i_rst_n: ;
      bus.i_mem_stall: begin
        w_pc_we    = 1'b0;
        w_if_id_we = 1'b0;
      end
      bus.i_ex_branch_taken: begin
        w_if_id_flush = 1'b1;
        w_id_ex_flush = 1'b1;
      end
      w_stall: begin
        w_pc_we       = 1'b0;
        w_if_id_we    = 1'b0;
        w_id_ex_flush = 1'b1;
      end
      w_jump: w_if_id_flush = 1'b1;
      default: ;
    endcase
  end

  assign w_bubble = w_id_ex_flush | ~bus.i_id_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else if (!bus.i_mem_stall) begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      if (w_bubble) begin
        r_ex <= '0;
      end else begin
        r_ex.valid   <= 1'b1;
        r_ex.writes  <= w_id.writes;
        r_ex.is_load <= w_id.is_load;
        r_ex.dest    <= w_id.dest;
      end
    end
  end

`ifdef MIPS_HAZARD_FORWARDING_EN
  logic [1:0] r_fwd_a;
  logic [1:0] r_fwd_b;

  // Youngest producer wins: EX/MEM result beats MEM/WB data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fwd_a <= FWD_SEL_REGFILE;
      r_fwd_b <= FWD_SEL_REGFILE;
    end else if (!bus.i_mem_stall) begin
      if (w_bubble) begin
        r_fwd_a <= FWD_SEL_REGFILE;
        r_fwd_b <= FWD_SEL_REGFILE;
      end else begin
        r_fwd_a <= w_s_ex  ? FWD_SEL_EXMEM :
                   w_s_mem ? FWD_SEL_MEMWB :
                             FWD_SEL_REGFILE;
        r_fwd_b <= w_t_ex  ? FWD_SEL_EXMEM :
                   w_t_mem ? FWD_SEL_MEMWB :
                             FWD_SEL_REGFILE;
      end
    end
  end

  assign bus.o_fwd_a_sel = r_fwd_a;
  assign bus.o_fwd_b_sel = r_fwd_b;
`else
  assign bus.o_fwd_a_sel = FWD_SEL_REGFILE;
  assign bus.o_fwd_b_sel = FWD_SEL_REGFILE;
`endif

  assign bus.o_pc_write_enable    = w_pc_we;
  assign bus.o_if_id_write_enable = w_if_id_we;
  assign bus.o_if_id_flush        = w_if_id_flush;
  assign bus.o_id_ex_flush        = w_id_ex_flush;
  assign bus.o_id_wb_bypass_a =
    hits(r_wb, w_id.s, w_id.reads_s);
  assign bus.o_id_wb_bypass_b =
    hits(r_wb, w_id.t, w_id.reads_t);

endmodule

// File: tb/tb_pipelined_mips_hazard_controller.sv
// Directed + random bench for the hazard controller, modelled per instruction kind.
// Model follows MIPS_HAZARD_FORWARDING_EN the same way the build does.
module tb_pipelined_mips_hazard_controller;
  import pipelined_mips_hazard_controller_pkg::*;

  typedef enum {K_ADD, K_ADDI, K_LW, K_SW, K_BEQ, K_J} kind_e;

  typedef struct {
    kind_e      k;
    logic [4:0] s;
    logic [4:0] t;
    logic [4:0] d;
  } ins_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_mips_hazard_controller_if bus ();

  pipelined_mips_hazard_controller dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int ncyc = 0;

  // In-flight instructions: index 0 = EX, 1 = MEM, 2 = WB.
  bit         mv[3];
  bit         mw[3];
  bit         ml[3];
  logic [4:0] md[3];
  logic [1:0] mfa;
  logic [1:0] mfb;

  function automatic ins_t mk(kind_e k, int s, int t, int d);
    ins_t i;
    i.k = k;
    i.s = 5'(s);
    i.t = 5'(t);
    i.d = 5'(d);
    return i;
  endfunction

  function automatic logic [CTRL_W-1:0] enc(ins_t i);
    logic jmp, br, was, wds, we, mwe;
    logic [1:0] ab;
    jmp = 0; br = 0; was = 0; wds = 0;
    we = 0; mwe = 0; ab = 2'b01;
    case (i.k)
      K_ADD:  begin was = 1; we = 1; ab = REGISTER_OUTPUT_2; end
      K_ADDI: we = 1;
      K_LW:   begin wds = 1; we = 1; end
      K_SW:   mwe = 1;
      K_BEQ:  begin br = 1; ab = REGISTER_OUTPUT_2; end
      K_J:    jmp = 1;
      default: ;
    endcase
    return {jmp, br, i.d, i.t, i.s, was, wds, we, mwe,
            3'b010, ab};
  endfunction

  function automatic bit hit(int st, logic [4:0] r, bit used);
    return used && mv[st] && mw[st]
        && r != 5'd0 && md[st] == r;
  endfunction

  task automatic chk(string tag, logic [1:0] obs, logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL c%0d %s observed=%0h expected=%0h",
             ncyc, tag, obs, exp);
    end
  endtask

  task automatic mclear();
    for (int k = 0; k < 3; k++) begin
      mv[k] = 0; mw[k] = 0; ml[k] = 0; md[k] = 0;
    end
    mfa = 0;
    mfb = 0;
  endtask

  task automatic chk_reset_outs();
    chk("rst_pc_we", {1'b0, bus.o_pc_write_enable}, 2'd1);
    chk("rst_ifid_we", {1'b0, bus.o_if_id_write_enable}, 2'd1);
    chk("rst_ifid_fl", {1'b0, bus.o_if_id_flush}, 2'd0);
    chk("rst_idex_fl", {1'b0, bus.o_id_ex_flush}, 2'd0);
    chk("rst_fwd_a", bus.o_fwd_a_sel, 2'd0);
    chk("rst_fwd_b", bus.o_fwd_b_sel, 2'd0);
    chk("rst_byp_a", {1'b0, bus.o_id_wb_bypass_a}, 2'd0);
    chk("rst_byp_b", {1'b0, bus.o_id_wb_bypass_b}, 2'd0);
  endtask

  // One clock: drive ID, check outputs against the model, advance model.
  task automatic cyc(ins_t i, bit v, bit br, bit st);
    bit rs, rt, wr, ld, jmp, hz, bub;
    bit hs0, ht0, hs1, ht1;
    logic [4:0] dst;
    logic [1:0] efa, efb;
    bit e_pc, e_we, e_iff, e_ief;
    rs  = (i.k != K_J);
    rt  = (i.k == K_ADD) || (i.k == K_SW) || (i.k == K_BEQ);
    dst = (i.k == K_ADD) ? i.d : i.t;
    wr  = (i.k == K_ADD || i.k == K_ADDI || i.k == K_LW)
       && dst != 0;
    ld  = (i.k == K_LW);
    jmp = (i.k == K_J);
    bus.i_id_control_signals = enc(i);
    bus.i_id_valid = v;
    bus.i_ex_branch_taken = br;
    bus.i_mem_stall = st;
    #1;
    hs0 = hit(0, i.s, rs);
    ht0 = hit(0, i.t, rt);
    hs1 = hit(1, i.s, rs);
    ht1 = hit(1, i.t, rt);
`ifdef MIPS_HAZARD_FORWARDING_EN
    hz  = v && ml[0] && (hs0 || ht0);
    efa = mfa;
    efb = mfb;
`else
    hz  = v && (hs0 || ht0 || hs1 || ht1);
    efa = 0;
    efb = 0;
`endif
    e_pc = 1; e_we = 1; e_iff = 0; e_ief = 0;
    if (st) begin
      e_pc = 0; e_we = 0;
    end else if (br) begin
      e_iff = 1; e_ief = 1;
    end else if (hz) begin
      e_pc = 0; e_we = 0; e_ief = 1;
    end else if (v && jmp) begin
      e_iff = 1;
    end
    chk("pc_we", {1'b0, bus.o_pc_write_enable}, {1'b0, e_pc});
    chk("ifid_we", {1'b0, bus.o_if_id_write_enable}, {1'b0, e_we});
    chk("ifid_flush", {1'b0, bus.o_if_id_flush}, {1'b0, e_iff});
    chk("idex_flush", {1'b0, bus.o_id_ex_flush}, {1'b0, e_ief});
    chk("fwd_a", bus.o_fwd_a_sel, efa);
    chk("fwd_b", bus.o_fwd_b_sel, efb);
    chk("byp_a", {1'b0, bus.o_id_wb_bypass_a},
        {1'b0, hit(2, i.s, rs)});
    chk("byp_b", {1'b0, bus.o_id_wb_bypass_b},
        {1'b0, hit(2, i.t, rt)});
    if (!st) begin
      bub = e_ief || !v;
      mfa = bub ? 2'd0 : hs0 ? 2'd1 : hs1 ? 2'd2 : 2'd0;
      mfb = bub ? 2'd0 : ht0 ? 2'd1 : ht1 ? 2'd2 : 2'd0;
      for (int k = 2; k > 0; k--) begin
        mv[k] = mv[k-1]; mw[k] = mw[k-1];
        ml[k] = ml[k-1]; md[k] = md[k-1];
      end
      mv[0] = !bub;
      mw[0] = !bub && wr;
      ml[0] = !bub && ld;
      md[0] = bub ? 5'd0 : dst;
    end
    ncyc++;
    @(negedge clk);
  endtask

  ins_t nop;
  ins_t ri;

  initial begin
    nop = mk(K_ADD, 0, 0, 0);
    mclear();
    bus.i_id_control_signals = enc(mk(K_LW, 1, 5, 0));
    bus.i_id_valid = 1;
    bus.i_ex_branch_taken = 1;
    bus.i_mem_stall = 1;
    #2;
    chk_reset_outs();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // add $3,$1,$2 ; dependent add/sub
    cyc(mk(K_ADD, 1, 2, 3), 1, 0, 0);
`ifdef MIPS_HAZARD_FORWARDING_EN
    cyc(mk(K_ADD, 3, 1, 4), 1, 0, 0);
    cyc(nop, 1, 0, 0);
`else
    cyc(mk(K_ADD, 3, 3, 4), 1, 0, 0);
    cyc(mk(K_ADD, 3, 3, 4), 1, 0, 0);
    cyc(mk(K_ADD, 3, 3, 4), 1, 0, 0);
    cyc(nop, 1, 0, 0);
`endif
    cyc(nop, 1, 0, 0);
    cyc(nop, 1, 0, 0);

    // lw $5 ; add $6,$5,$5 (load-use)
    cyc(mk(K_LW, 1, 5, 0), 1, 0, 0);
    for (int k = 0; k < 4; k++)
      cyc(mk(K_ADD, 5, 5, 6), 1, 0, 0);
    cyc(nop, 1, 0, 0);
    cyc(nop, 1, 0, 0);

    // taken branch squashes a load-use consumer
    cyc(mk(K_LW, 1, 5, 0), 1, 0, 0);
    cyc(mk(K_ADD, 5, 5, 6), 1, 1, 0);
    cyc(mk(K_ADD, 5, 5, 6), 1, 0, 0);
    cyc(nop, 1, 0, 0);
    cyc(nop, 1, 0, 0);

    // jump, then writes to $0 never match
    cyc(mk(K_J, 0, 0, 0), 1, 0, 0);
    cyc(mk(K_ADDI, 1, 0, 0), 1, 0, 0);
    cyc(mk(K_ADD, 0, 0, 2), 1, 0, 0);
    cyc(mk(K_ADD, 0, 0, 2), 1, 0, 0);
    cyc(mk(K_ADD, 0, 0, 2), 1, 0, 0);

    // external freeze held across a load-use stall
    cyc(mk(K_LW, 1, 5, 0), 1, 0, 0);
    for (int k = 0; k < 3; k++)
      cyc(mk(K_ADD, 5, 5, 6), 1, 0, 1);
    for (int k = 0; k < 4; k++)
      cyc(mk(K_ADD, 5, 5, 6), 1, 0, 0);

    // async reset while frozen in a stall
    cyc(mk(K_LW, 1, 5, 0), 1, 0, 0);
    cyc(mk(K_ADD, 5, 5, 6), 1, 0, 1);
    bus.i_id_control_signals = enc(mk(K_ADD, 5, 5, 6));
    rst_n = 0;
    #1;
    chk_reset_outs();
    mclear();
    #1;
    rst_n = 1;
    @(negedge clk);
    cyc(mk(K_ADD, 5, 5, 6), 1, 0, 0);

    for (int n = 0; n < 400; n++) begin
      ri = mk(kind_e'($urandom_range(0, 5)),
              $urandom_range(0, 3),
              $urandom_range(0, 3),
              $urandom_range(0, 3));
      cyc(ri, ($urandom % 10) != 0,
          ($urandom % 10) == 0,
          ($urandom % 7) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
